// File: rtl/thermo_code_gen.sv
// Binary-to-thermometer pattern generator: single direct codes via valid/ready, or a self-timed 0..WIDTH sweep.
// Optional BUBBLE_INJECT_EN adds bubble_en_i/bubble_pos_i to force one tap low, emulating a metastable delay-line bit.
module thermo_code_gen #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BIN_W       = 6,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sweep_dn_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_code,
`ifdef BUBBLE_INJECT_EN
    input  logic             bubble_en_i,
    input  logic [BIN_W-1:0] bubble_pos_i,
`endif
    output logic [WIDTH-1:0] thermo_o,
    output logic             thermo_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned      HOLD_W    = 8;
    localparam int unsigned      BIN_W1    = BIN_W + 1;
    localparam logic [BIN_W-1:0] CODE_MAX  = BIN_W'(WIDTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SWEEP  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    code_q, code_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    word_d;
    logic                valid_d, busy_d, done_d, err_d;
    logic [BIN_W-1:0]    in_clamp, step_code;
    logic                last_code;
    logic                bub_en;
    logic [BIN_W-1:0]    bub_pos;

`ifdef BUBBLE_INJECT_EN
    assign bub_en  = bubble_en_i;
    assign bub_pos = bubble_pos_i;
`else
    assign bub_en  = 1'b0;
    assign bub_pos = '0;
`endif

    // Thermometer word with an optional single cleared tap strictly below the top one.
    function automatic logic [WIDTH-1:0] make_word(input logic [BIN_W-1:0] code,
                                                   input logic             b_en,
                                                   input logic [BIN_W-1:0] b_pos);
        logic [WIDTH-1:0] w;
        w = ~({WIDTH{1'b1}} << code);
        if (b_en && (({1'b0, b_pos} + BIN_W1'(1)) < {1'b0, code}))
            w = w & ~(WIDTH'(1) << b_pos);
        return w;
    endfunction

    // Held off in reset so the handshake only opens once the FSM is live.
    assign in_ready = rst_n & (state_q == IDLE) & ~start_i;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        hold_d    = hold_q;
        dir_d     = dir_q;
        word_d    = thermo_o;
        valid_d   = thermo_valid_o;
        done_d    = 1'b0;
        err_d     = 1'b0;
        in_clamp  = (in_code > CODE_MAX) ? CODE_MAX : in_code;
        step_code = dir_q ? (code_q - BIN_W'(1)) : (code_q + BIN_W'(1));
        last_code = dir_q ? (code_q == '0) : (code_q == CODE_MAX);

        unique case (state_q)
            IDLE: begin
                word_d  = '0;
                valid_d = 1'b0;
                if (start_i) begin
                    state_d = SWEEP;
                    dir_d   = sweep_dn_i;
                    code_d  = sweep_dn_i ? CODE_MAX : '0;
                    word_d  = make_word(code_d, bub_en, bub_pos);
                    valid_d = 1'b1;
                    hold_d  = HOLD_LOAD;
                end else if (in_valid && in_ready) begin
                    state_d = DIRECT;
                    code_d  = in_clamp;
                    word_d  = make_word(in_clamp, bub_en, bub_pos);
                    valid_d = 1'b1;
                    err_d   = (in_code > CODE_MAX);
                    hold_d  = HOLD_LOAD;
                end
            end
            DIRECT: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                    word_d  = '0;
                    valid_d = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            SWEEP: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (last_code) begin
                    state_d = FIN;
                    word_d  = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    code_d = step_code;
                    word_d = make_word(step_code, bub_en, bub_pos);
                    hold_d = HOLD_LOAD;
                end
            end
            FIN: begin
                state_d = IDLE;
                word_d  = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                word_d  = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            code_q         <= '0;
            hold_q         <= '0;
            dir_q          <= 1'b0;
            thermo_o       <= '0;
            thermo_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            hold_q         <= hold_d;
            dir_q          <= dir_d;
            thermo_o       <= word_d;
            thermo_valid_o <= valid_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
            err_o          <= err_d;
        end
    end

endmodule
